// File: rtl/kd_pkg.sv
// Shared constants for the Kyber/Dilithium modular multiplier.
//   KQ / DQ         : Kyber and Dilithium moduli
//   KK, KMW, KM     : Kyber Barrett shift, constant width, constant floor(2^24/3329)
//   DK, DMW, DM     : Dilithium Barrett shift, constant width, constant floor(2^48/8380417)
//   MODE_KYBER/DIL  : encoding of mul_mode
package kd_pkg;

    localparam logic [11:0] KQ = 12'd3329;
    localparam logic [23:0] DQ = 24'd8380417;

    localparam int unsigned     KK  = 24;
    localparam int unsigned     KMW = 13;
    localparam logic [KMW-1:0]  KM  = 13'd5039;

    localparam int unsigned     DK  = 48;
    localparam int unsigned     DMW = 26;
    // floor(2^48 / 8380417): 33587228 * 8380417 = 2^48 - 196580
    localparam logic [DMW-1:0]  DM  = 26'd33587228;

    localparam logic MODE_KYBER = 1'b0;
    localparam logic MODE_DIL   = 1'b1;

endpackage

// File: rtl/barrett_red.sv
// Barrett reduction of a 2W-bit product modulo a W-bit modulus.
// Stage S3 (registered): qhat = (p * M) >> K, r = p - qhat * Q.
// Stage S4 (combinational): up to two conditional subtractions of Q; the caller registers r_o.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   en_i         : advance the S3 register
//   p_i          : product to reduce (valid for p_i < 2^K)
//   r_o          : p_i mod Q, in [0, Q-1]
module barrett_red #(
    parameter int unsigned      W  = 12,
    parameter int unsigned      K  = 24,
    parameter int unsigned      MW = 13,
    parameter logic [W-1:0]     Q  = 12'd3329,
    parameter logic [MW-1:0]    M  = 13'd5039
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [2*W-1:0]  p_i,
    output logic [W-1:0]    r_o
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned XW = PW + MW;
    localparam int unsigned QW = XW - K;
    // With p < 2^K the estimate is short by at most one, so r < 2q fits in W+2 bits.
    localparam int unsigned RW = W + 2;
    localparam logic [RW-1:0] QX = {2'b00, Q};

    logic [XW-1:0]   pm;
    logic [QW-1:0]   qhat;
    logic [QW+W-1:0] qq;
    logic [RW-1:0]   r_d, r_q;
    logic [RW-1:0]   t1, t2;

    always_comb begin
        pm   = {{MW{1'b0}}, p_i} * {{PW{1'b0}}, M};
        qhat = pm[XW-1:K];
        qq   = {{W{1'b0}}, qhat} * {{QW{1'b0}}, Q};
        // Only the low bits matter: the true difference is known to fit in RW bits.
        r_d  = p_i[RW-1:0] - qq[RW-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q <= '0;
        end else if (en_i) begin
            r_q <= r_d;
        end
    end

    always_comb begin
        t1  = (r_q >= QX) ? (r_q - QX) : r_q;
        t2  = (t1 >= QX) ? (t1 - QX) : t1;
        r_o = t2[W-1:0];
    end

endmodule

// File: rtl/mod_mul_kd.sv
// Pipelined dual-mode modular multiplier (Kyber 2x12-bit mod 3329 / Dilithium 24-bit mod 8380417).
// Four stages: S1 input regs, S2 products, S3 Barrett estimate, S4 correction + output regs.
// Optional feature macro: MODMUL_STALL_EN adds the stall port (freezes every stage register).
//   clk, rst            : clock, asynchronous active-high reset
//   valid_in, mul_mode  : operation strobe, 0 = Kyber dual-lane, 1 = Dilithium
//   a, b                : operands, Kyber packs {hi, lo} 12-bit lanes
//   tag_in              : sideband tag carried with the operation
//   stall               : pipeline freeze (MODMUL_STALL_EN only)
//   valid_out, product, tag_out : registered result, 4 cycles after valid_in
module mod_mul_kd
    import kd_pkg::*;
#(
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MODMUL_STALL_EN
    input  logic             stall,
`endif
    input  logic             valid_in,
    input  logic             mul_mode,
    input  logic [23:0]      a,
    input  logic [23:0]      b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             valid_out,
    output logic [23:0]      product,
    output logic [TAG_W-1:0] tag_out
);

    logic adv;
`ifdef MODMUL_STALL_EN
    assign adv = ~stall;
`else
    assign adv = 1'b1;
`endif

    // S1
    logic             v1_q, m1_q;
    logic [23:0]      a1_q, b1_q;
    logic [TAG_W-1:0] t1_q;
    // S2
    logic             v2_q, m2_q;
    logic [TAG_W-1:0] t2_q;
    logic [23:0]      plo_d, phi_d, plo_q, phi_q;
    logic [47:0]      pd_d, pd_q;
    // S3 (data lives inside barrett_red)
    logic             v3_q, m3_q;
    logic [TAG_W-1:0] t3_q;
    // S4
    logic             v4_q;
    logic [23:0]      prod_d, prod_q;
    logic [TAG_W-1:0] t4_q;

    logic [11:0] rlo, rhi;
    logic [23:0] rdil;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            m1_q <= MODE_KYBER;
            a1_q <= '0;
            b1_q <= '0;
            t1_q <= '0;
        end else if (adv) begin
            v1_q <= valid_in;
            m1_q <= mul_mode;
            a1_q <= a;
            b1_q <= b;
            t1_q <= tag_in;
        end
    end

    always_comb begin
        // Separate lane multipliers keep the Kyber lanes free of any cross-lane carry.
        plo_d = {12'b0, a1_q[11:0]} * {12'b0, b1_q[11:0]};
        phi_d = {12'b0, a1_q[23:12]} * {12'b0, b1_q[23:12]};
        pd_d  = {24'b0, a1_q} * {24'b0, b1_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q  <= 1'b0;
            m2_q  <= MODE_KYBER;
            t2_q  <= '0;
            plo_q <= '0;
            phi_q <= '0;
            pd_q  <= '0;
        end else if (adv) begin
            v2_q  <= v1_q;
            m2_q  <= m1_q;
            t2_q  <= t1_q;
            plo_q <= plo_d;
            phi_q <= phi_d;
            pd_q  <= pd_d;
        end
    end

    barrett_red #(
        .W  (12),
        .K  (KK),
        .MW (KMW),
        .Q  (KQ),
        .M  (KM)
    ) u_red_lo (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (adv),
        .p_i   (plo_q),
        .r_o   (rlo)
    );

    barrett_red #(
        .W  (12),
        .K  (KK),
        .MW (KMW),
        .Q  (KQ),
        .M  (KM)
    ) u_red_hi (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (adv),
        .p_i   (phi_q),
        .r_o   (rhi)
    );

    barrett_red #(
        .W  (24),
        .K  (DK),
        .MW (DMW),
        .Q  (DQ),
        .M  (DM)
    ) u_red_dil (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (adv),
        .p_i   (pd_q),
        .r_o   (rdil)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q <= 1'b0;
            m3_q <= MODE_KYBER;
            t3_q <= '0;
        end else if (adv) begin
            v3_q <= v2_q;
            m3_q <= m2_q;
            t3_q <= t2_q;
        end
    end

    always_comb begin
        prod_d = (m3_q == MODE_DIL) ? rdil : {rhi, rlo};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v4_q   <= 1'b0;
            prod_q <= '0;
            t4_q   <= '0;
        end else if (adv) begin
            v4_q   <= v3_q;
            prod_q <= prod_d;
            t4_q   <= t3_q;
        end
    end

    assign valid_out = v4_q;
    assign product   = prod_q;
    assign tag_out   = t4_q;

endmodule

// File: tb/tb_mod_mul_kd.sv
module tb_mod_mul_kd;

    logic        clk;
    logic        rst;
`ifdef MODMUL_STALL_EN
    logic        stall;
`endif
    logic        valid_in;
    logic        mul_mode;
    logic [23:0] a;
    logic [23:0] b;
    logic [7:0]  tag_in;
    logic        valid_out;
    logic [23:0] product;
    logic [7:0]  tag_out;

    int total = 0;
    int bad   = 0;

    mod_mul_kd #(
        .TAG_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MODMUL_STALL_EN
        .stall     (stall),
`endif
        .valid_in  (valid_in),
        .mul_mode  (mul_mode),
        .a         (a),
        .b         (b),
        .tag_in    (tag_in),
        .valid_out (valid_out),
        .product   (product),
        .tag_out   (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] exp;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [23:0] ref_mul(input logic mode, input logic [23:0] x,
                                            input logic [23:0] y);
        logic [63:0] p;
        int unsigned hi, lo;
        if (mode) begin
            p = 64'(x) * 64'(y);
            return 24'(p % 64'd8380417);
        end
        hi = (32'(x[23:12]) * 32'(y[23:12])) % 32'd3329;
        lo = (32'(x[11:0]) * 32'(y[11:0])) % 32'd3329;
        return {hi[11:0], lo[11:0]};
    endfunction

    task automatic drive(input logic v, input logic m, input logic [23:0] x,
                         input logic [23:0] y, input logic [7:0] t);
        valid_in = v;
        mul_mode = m;
        a        = x;
        b        = y;
        tag_in   = t;
    endtask

    // Single operation; checks valid_out stays low for 3 cycles and rises on the 4th.
    task automatic run_one(input string name, input logic m, input logic [23:0] x,
                           input logic [23:0] y, input logic [7:0] t, input logic [23:0] exp);
        @(negedge clk);
        drive(1'b1, m, x, y, t);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) valid_in = 1'b0;
            if (k < 4) begin
                chk({name, "_early"}, {47'b0, valid_out}, 48'd0);
            end else begin
                chk({name, "_vo"}, {47'b0, valid_out}, 48'd1);
                chk({name, "_prod"}, {24'b0, product}, {24'b0, exp});
                chk({name, "_tag"}, {40'b0, tag_out}, {40'b0, t});
            end
        end
    endtask

    task automatic run_stream();
        logic        sv[64];
        logic        sm[64];
        logic [23:0] sa[64];
        logic [23:0] sb[64];
        logic [7:0]  st[64];
        for (int i = 0; i < 64; i++) begin
            sv[i] = (i % 4) != 3;
            sm[i] = (i % 2) == 1;
            sa[i] = 24'($urandom);
            sb[i] = 24'($urandom);
            st[i] = 8'(i + 8'h40);
        end
        sa[5] = 24'hFFFFFF;
        sb[5] = 24'hFFFFFF;
        sa[6] = 24'hFFFFFF;
        sb[6] = 24'hFFFFFF;
        for (int c = 0; c < 68; c++) begin
            @(negedge clk);
            if (c >= 4) begin
                chk("stream_vo", {47'b0, valid_out}, {47'b0, sv[c-4]});
                if (sv[c-4]) begin
                    chk("stream_prod", {24'b0, product},
                        {24'b0, ref_mul(sm[c-4], sa[c-4], sb[c-4])});
                    chk("stream_tag", {40'b0, tag_out}, {40'b0, st[c-4]});
                end
            end
            if (c < 64) drive(sv[c], sm[c], sa[c], sb[c], st[c]);
            else valid_in = 1'b0;
        end
    endtask

    task automatic run_reset_flush();
        @(negedge clk);
        drive(1'b1, 1'b0, 24'h123456, 24'h654321, 8'hA0);
        @(negedge clk);
        drive(1'b1, 1'b1, 24'h0ABCDE, 24'h012345, 8'hA1);
        @(negedge clk);
        drive(1'b1, 1'b0, 24'hFFF001, 24'h002FFF, 8'hA2);
        @(negedge clk);
        // Three operations in flight; valid_in coincident with reset must be dropped too.
        drive(1'b1, 1'b1, 24'h000777, 24'h000888, 8'hA3);
        rst = 1'b1;
        #1;
        chk("flush_vo", {47'b0, valid_out}, 48'd0);
        chk("flush_prod", {24'b0, product}, 48'd0);
        chk("flush_tag", {40'b0, tag_out}, 48'd0);
        @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("flush_quiet", {47'b0, valid_out}, 48'd0);
        end
        run_one("post_rst", 1'b0, {12'd3328, 12'd2}, {12'd3328, 12'd1665}, 8'h5A,
                {12'd1, 12'd1});
    endtask

`ifdef MODMUL_STALL_EN
    task automatic run_stall();
        logic [23:0] xa[4];
        logic [23:0] xb[4];
        logic        xm[4];
        xa[0] = 24'd8380416; xb[0] = 24'd8380416; xm[0] = 1'b1;
        xa[1] = {12'd1234, 12'd3000}; xb[1] = {12'd2000, 12'd5}; xm[1] = 1'b0;
        xa[2] = 24'd12345; xb[2] = 24'd6789; xm[2] = 1'b1;
        xa[3] = {12'd4095, 12'd4095}; xb[3] = {12'd4095, 12'd4095}; xm[3] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1'b1, xm[c], xa[c], xb[c], 8'(8'hC0 + c));
        end
        @(negedge clk);
        chk("stall_pre_vo", {47'b0, valid_out}, 48'd1);
        chk("stall_pre_tag", {40'b0, tag_out}, 48'hC0);
        // Stall for 5 edges while offering an operation that must never be sampled.
        stall = 1'b1;
        drive(1'b1, 1'b0, 24'h00F00F, 24'h00F00F, 8'hEE);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_vo", {47'b0, valid_out}, 48'd1);
            chk("stall_prod", {24'b0, product}, 48'd1);
            chk("stall_tag", {40'b0, tag_out}, 48'hC0);
        end
        stall    = 1'b0;
        valid_in = 1'b0;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            chk("unstall_vo", {47'b0, valid_out}, 48'd1);
            chk("unstall_prod", {24'b0, product}, {24'b0, ref_mul(xm[c], xa[c], xb[c])});
            chk("unstall_tag", {40'b0, tag_out}, {40'b0, 8'(8'hC0 + c)});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("unstall_drain", {47'b0, valid_out}, 48'd0);
        end
    endtask
`endif

    initial begin
        vt[0] = '{1'b0, {12'd3328, 12'd2},    {12'd3328, 12'd1665}, {12'd1, 12'd1}};
        vt[1] = '{1'b0, {12'd4095, 12'd0},    {12'd1, 12'd3328},    {12'd766, 12'd0}};
        vt[2] = '{1'b0, 24'd0,                24'd0,                24'd0};
        vt[3] = '{1'b1, 24'd8380416,          24'd8380416,          24'd1};
        vt[4] = '{1'b1, 24'd8388608,          24'd1,                24'd8191};
        vt[5] = '{1'b1, 24'd16777215,         24'd16777215,         24'd163817};
        vt[6] = '{1'b0, {12'd1234, 12'd3000}, {12'd2000, 12'd5},    {12'd1211, 12'd1684}};
        vt[7] = '{1'b1, 24'd12345,            24'd6789,             24'd6035};
        vt[8] = '{1'b0, {12'd4095, 12'd4095}, {12'd4095, 12'd4095}, {12'd852, 12'd852}};
        vt[9] = '{1'b1, 24'd0,                24'd16777215,         24'd0};

        rst = 1'b1;
`ifdef MODMUL_STALL_EN
        stall = 1'b0;
`endif
        drive(1'b0, 1'b0, 24'd0, 24'd0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_vo", {47'b0, valid_out}, 48'd0);
        chk("rst_prod", {24'b0, product}, 48'd0);
        chk("rst_tag", {40'b0, tag_out}, 48'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_one($sformatf("vec%0d", i), vt[i].mode, vt[i].a, vt[i].b, 8'(8'h10 + i),
                    vt[i].exp);
        end

        run_stream();
        run_reset_flush();
`ifdef MODMUL_STALL_EN
        run_stall();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
